// File: rtl/bus_pkg.sv
// Shared bus constants, FSM state type and CRC-4 step function.
// Used by the per-node receiver and the bus transmitter.
package bus_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 64;
   localparam int CRC_W  = 4;

   localparam logic [CRC_W-1:0]  CRC_POLY   = 4'h3;
   localparam logic [ADDR_W-1:0] BCAST_ADDR = 4'hF;
   localparam int FRAME_BITS = 1 + 2*ADDR_W + DATA_W + CRC_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SRC,
      ST_DST,
      ST_DATA,
      ST_CRC
   } bus_state_e;

   function automatic logic [CRC_W-1:0] crc4_step(
      input logic [CRC_W-1:0] c,
      input logic             b
   );
      logic fb;
      fb = b ^ c[CRC_W-1];
      return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
   endfunction

endpackage

// File: rtl/crc4_serial.sv
// Bit-serial CRC-4 (x^4+x+1), one bit per enabled clock.
// Ports: clock, reset, clr (sync clear), en, bit_in -> crc.
module crc4_serial
   import bus_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc
);

   logic [CRC_W-1:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr)
         crc_d = '0;
      else if (en)
         crc_d = crc4_step(crc_q, bit_in);
   end

   always_ff @(posedge clock) begin
      if (reset)
         crc_q <= '0;
      else
         crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/bus_frame_receiver.sv
// Serial bus frame receiver: start|src|dst|data|crc, CRC + dst filter.
// Ports: clock, reset, bus_in, rx_ready -> rx_valid/src/data/bcast, crc_err, overrun, busy.
module bus_frame_receiver
   import bus_pkg::*;
#(
   parameter logic [ADDR_W-1:0] NODE_ADDR = 4'd1
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              bus_in,
   input  logic              rx_ready,
   output logic              rx_valid,
   output logic [ADDR_W-1:0] rx_src,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_bcast,
   output logic              crc_err,
   output logic              overrun,
   output logic              busy
);

   localparam int SH_W = 2*ADDR_W + DATA_W;

   bus_state_e        state_q, state_d;
   logic [6:0]        cnt_q, cnt_d;
   logic [SH_W-1:0]   sh_q, sh_d;
   logic [CRC_W-1:0]  crx_q, crx_d;
   logic [CRC_W-1:0]  crc_calc;

   logic              vld_q, vld_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic              bc_q, bc_d;
   logic              err_q, err_d;
   logic              ovr_q, ovr_d;

   logic              shift_en;
   logic              last;
   logic [ADDR_W-1:0] f_src, f_dst;
   logic [CRC_W-1:0]  crc_rx;
   logic              addr_ok;

   assign shift_en = (state_q == ST_SRC) ||
                     (state_q == ST_DST) ||
                     (state_q == ST_DATA);

   crc4_serial u_crc (
      .clock  (clock),
      .reset  (reset),
      .clr    (state_q == ST_IDLE),
      .en     (shift_en),
      .bit_in (bus_in),
      .crc    (crc_calc)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 7'd1;
      sh_d    = sh_q;
      crx_d   = crx_q;
      if (shift_en)
         sh_d = {sh_q[SH_W-2:0], bus_in};
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus_in) state_d = ST_SRC;
         end
         ST_SRC: if (cnt_q == 7'(ADDR_W-1)) begin
            state_d = ST_DST;
            cnt_d   = '0;
         end
         ST_DST: if (cnt_q == 7'(ADDR_W-1)) begin
            state_d = ST_DATA;
            cnt_d   = '0;
         end
         ST_DATA: if (cnt_q == 7'(DATA_W-1)) begin
            state_d = ST_CRC;
            cnt_d   = '0;
         end
         ST_CRC: begin
            crx_d = {crx_q[CRC_W-2:0], bus_in};
            if (cnt_q == 7'(CRC_W-1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The final crc bit is still on the wire, so splice it in here.
   assign last    = (state_q == ST_CRC) && (cnt_q == 7'(CRC_W-1));
   assign crc_rx  = {crx_q[CRC_W-2:0], bus_in};
   assign f_src   = sh_q[DATA_W+ADDR_W +: ADDR_W];
   assign f_dst   = sh_q[DATA_W +: ADDR_W];
   assign addr_ok = (f_dst == NODE_ADDR) || (f_dst == BCAST_ADDR);

   always_comb begin
      vld_d = vld_q;
      src_d = src_q;
      dat_d = dat_q;
      bc_d  = bc_q;
      err_d = 1'b0;
      ovr_d = 1'b0;
      if (vld_q && rx_ready)
         vld_d = 1'b0;
      if (last && addr_ok) begin
         if (crc_calc != crc_rx) begin
            err_d = 1'b1;
         end else if (vld_q && !rx_ready) begin
            ovr_d = 1'b1;
         end else begin
            vld_d = 1'b1;
            src_d = f_src;
            dat_d = sh_q[DATA_W-1:0];
            bc_d  = (f_dst == BCAST_ADDR);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         crx_q   <= '0;
         vld_q   <= 1'b0;
         src_q   <= '0;
         dat_q   <= '0;
         bc_q    <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         crx_q   <= crx_d;
         vld_q   <= vld_d;
         src_q   <= src_d;
         dat_q   <= dat_d;
         bc_q    <= bc_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rx_valid = vld_q;
   assign rx_src   = src_q;
   assign rx_data  = dat_q;
   assign rx_bcast = bc_q;
   assign crc_err  = err_q;
   assign overrun  = ovr_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_frame_receiver.sv
// Scoreboard bench for bus_frame_receiver (NODE_ADDR=2).
// Frame-level reference model; outputs sampled on the falling edge.
module tb_bus_frame_receiver;

   localparam logic [3:0] NODE = 4'd2;
   localparam logic [3:0] BC   = 4'hF;

   logic        clock = 1'b0;
   logic        reset;
   logic        bus_in;
   logic        rx_ready;
   logic        rx_valid;
   logic [3:0]  rx_src;
   logic [63:0] rx_data;
   logic        rx_bcast;
   logic        crc_err;
   logic        overrun;
   logic        busy;

   always #5 clock = ~clock;

   bus_frame_receiver #(.NODE_ADDR(NODE)) dut (
      .clock    (clock),
      .reset    (reset),
      .bus_in   (bus_in),
      .rx_ready (rx_ready),
      .rx_valid (rx_valid),
      .rx_src   (rx_src),
      .rx_data  (rx_data),
      .rx_bcast (rx_bcast),
      .crc_err  (crc_err),
      .overrun  (overrun),
      .busy     (busy)
   );

   typedef struct {
      logic [3:0]  src;
      logic [63:0] data;
      logic        bcast;
   } frm_t;

   frm_t sb_q[$];

   int   total = 0;
   int   bad   = 0;
   int   rdy_mode = 1;
   int   seen_err = 0;
   int   seen_ovr = 0;
   int   busy_cnt = 0;
   int   n_dlv = 0;
   int   n_ok_sent = 0;
   logic m_valid, exp_err, exp_ovr, exp_busy;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] crc_of(input logic [71:0] v);
      logic [3:0] c;
      logic fb;
      c = 4'h0;
      for (int i = 71; i >= 0; i--) begin
         fb = v[i] ^ c[3];
         c = {c[2:0], 1'b0} ^ (fb ? 4'h3 : 4'h0);
      end
      return c;
   endfunction

   function automatic logic get_rdy();
      if (rdy_mode == 2) return 1'($urandom_range(0, 1));
      return (rdy_mode != 0);
   endfunction

   task automatic cycle(input logic b, input logic r,
                        input logic nb, input logic last,
                        input logic ours, input logic good,
                        input frm_t f);
      logic rdy, acc;
      frm_t e;
      @(negedge clock);
      check("rx_valid", rx_valid, m_valid);
      check("crc_err", crc_err, exp_err);
      check("overrun", overrun, exp_ovr);
      check("busy", busy, exp_busy);
      if (crc_err) seen_err++;
      if (overrun) seen_ovr++;
      if (busy) busy_cnt++;
      rdy = get_rdy();
      acc = m_valid && rdy && !r;
      if (acc) begin
         if (sb_q.size() == 0) begin
            check("sb_under", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("dlv_src", rx_src, e.src);
            check("dlv_data", rx_data, e.data);
            check("dlv_bcast", rx_bcast, e.bcast);
            n_dlv++;
         end
      end
      bus_in   = b;
      rx_ready = rdy;
      reset    = r;
      if (r) begin
         m_valid  = 1'b0;
         exp_err  = 1'b0;
         exp_ovr  = 1'b0;
         exp_busy = 1'b0;
         sb_q.delete();
      end else begin
         exp_err  = 1'b0;
         exp_ovr  = 1'b0;
         exp_busy = nb;
         if (acc) m_valid = 1'b0;
         if (last && ours) begin
            if (!good) begin
               exp_err = 1'b1;
            end else if (m_valid) begin
               exp_ovr = 1'b1;
            end else begin
               m_valid = 1'b1;
               sb_q.push_back(f);
            end
         end
      end
   endtask

   task automatic idle(input int n);
      frm_t f;
      f = '{src: 4'h0, data: 64'h0, bcast: 1'b0};
      for (int i = 0; i < n; i++)
         cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, f);
   endtask

   task automatic send(input logic [3:0] src, input logic [3:0] dst,
                       input logic [63:0] data, input logic [3:0] crc,
                       input int abort_at);
      logic [76:0] v;
      logic ours, good, r;
      frm_t f;
      v    = {1'b1, src, dst, data, crc};
      ours = (dst == NODE) || (dst == BC);
      good = (crc == crc_of({src, dst, data}));
      f    = '{src: src, data: data, bcast: (dst == BC)};
      if (ours && good && abort_at < 0) n_ok_sent++;
      for (int i = 0; i < 77; i++) begin
         r = (i == abort_at);
         cycle(r ? 1'b0 : v[76-i], r, !r && (i < 76),
               (i == 76), ours, good, f);
         if (r) break;
      end
   endtask

   initial begin
      logic [63:0] d;
      logic [3:0]  s, t, c;
      int e0, o0, b0, d0, k0;
      reset    = 1'b1;
      bus_in   = 1'b0;
      rx_ready = 1'b0;
      m_valid  = 1'b0;
      exp_err  = 1'b0;
      exp_ovr  = 1'b0;
      exp_busy = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_valid", rx_valid, 0);
      check("rst_src", rx_src, 0);
      check("rst_data", rx_data, 0);
      check("rst_bcast", rx_bcast, 0);
      check("rst_err", crc_err, 0);
      check("rst_ovr", overrun, 0);
      check("rst_busy", busy, 0);

      rdy_mode = 1;
      idle(2);
      d0 = n_dlv;
      send(4'h1, NODE, 64'h1, 4'h6, -1);
      idle(3);
      check("t1_dlv", n_dlv - d0, 1);

      e0 = seen_err;
      d0 = n_dlv;
      send(4'h1, NODE, 64'h1, 4'h7, -1);
      idle(3);
      check("t2_err", seen_err - e0, 1);
      check("t2_dlv", n_dlv - d0, 0);

      b0 = busy_cnt;
      e0 = seen_err;
      d0 = n_dlv;
      send(4'h1, 4'h3, 64'h1, crc_of({4'h1, 4'h3, 64'h1}), -1);
      idle(3);
      check("t3_busy", busy_cnt - b0, 76);
      check("t3_err", seen_err - e0, 0);
      check("t3_dlv", n_dlv - d0, 0);

      rdy_mode = 0;
      o0 = seen_ovr;
      send(4'h1, NODE, 64'h1, crc_of({4'h1, NODE, 64'h1}), -1);
      send(4'h1, NODE, 64'h2, crc_of({4'h1, NODE, 64'h2}), -1);
      idle(2);
      check("t4_data", rx_data, 64'h1);
      check("t4_ovr", seen_ovr - o0, 1);
      rdy_mode = 1;
      idle(2);
      check("t4_drop", rx_valid, 0);

      d0 = n_dlv;
      d  = 64'hA5A5_0F0F_1234_5678;
      send(4'h5, NODE, d, crc_of({4'h5, NODE, d}), 39);
      idle(2);
      d  = 64'hDEAD_BEEF_CAFE_F00D;
      send(4'h3, BC, d, crc_of({4'h3, BC, d}), -1);
      idle(3);
      check("t5_dlv", n_dlv - d0, 1);

      rdy_mode  = 2;
      o0        = seen_ovr;
      d0        = n_dlv;
      k0        = n_ok_sent;
      for (int n = 0; n < 1000; n++) begin
         s = 4'($urandom);
         d = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0, 3:    t = NODE;
            1:       t = BC;
            default: t = 4'($urandom);
         endcase
         c = crc_of({s, t, d});
         if ($urandom_range(0, 7) == 0)
            c = c ^ 4'($urandom_range(1, 15));
         send(s, t, d, c, -1);
         if ($urandom_range(0, 7) == 0) idle(1);
      end
      rdy_mode = 1;
      idle(4);
      check("t6_sb_empty", sb_q.size(), 0);
      check("t6_conserve", (n_dlv - d0) + (seen_ovr - o0),
            n_ok_sent - k0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
